// File: rtl/tl_d_pkg.sv
// TileLink D-channel constants and fragment helpers
// shared by the fragment coalescer slice.
package tl_d_pkg;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam int FRAG_W = 3;

  function automatic logic [2:0] frag_log2(
    input logic [FRAG_W-1:0] frag
  );
    logic [2:0] r;
    r = 3'd0;
    unique case (frag)
      3'd1:    r = 3'd1;
      3'd3:    r = 3'd2;
      3'd7:    r = 3'd3;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fragment_size_restore.sv
// Restores the message size from the first fragment beat
// and tracks whether the next beat starts a message.
module fragment_size_restore
  import tl_d_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_fire,
  input  logic [2:0]        in_size,
  input  logic [FRAG_W-1:0] in_frag,
  output logic              first,
  output logic [2:0]        out_size
);

  logic [2:0] saved_size;
  logic [2:0] calc_size;

  assign calc_size = in_size + frag_log2(in_frag);
  assign out_size  = first ? calc_size : saved_size;

  always_ff @(posedge clock) begin
    if (reset) begin
      first      <= 1'b1;
      saved_size <= 3'd0;
    end else if (in_fire) begin
      if (first) saved_size <= calc_size;
      first <= (in_frag == '0);
    end
  end

endmodule

// File: rtl/fragment_coalescer.sv
// Merges fragment responses into one D-channel response.
// FRAGMENT_COALESCER_CHECK_EN adds simulation-only checks.
module fragment_coalescer
  import tl_d_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic        io_in_ready,
  input  logic        io_in_valid,
  input  logic [2:0]  io_in_bits_opcode,
  input  logic [1:0]  io_in_bits_param,
  input  logic [2:0]  io_in_bits_size,
  input  logic [6:0]  io_in_bits_source,
  input  logic [2:0]  io_in_bits_frag,
  input  logic        io_in_bits_denied,
  input  logic [63:0] io_in_bits_data,
  input  logic        io_in_bits_corrupt,
  input  logic        io_out_ready,
  output logic        io_out_valid,
  output logic [2:0]  io_out_bits_opcode,
  output logic [1:0]  io_out_bits_param,
  output logic [2:0]  io_out_bits_size,
  output logic [6:0]  io_out_bits_source,
  output logic        io_out_bits_denied,
  output logic [63:0] io_out_bits_data,
  output logic        io_out_bits_corrupt
);

  logic first;
  logic sticky_denied;
  logic is_ack;
  logic last;
  logic drop;
  logic in_fire;
  logic out_denied;

  assign is_ack  = (io_in_bits_opcode == ACCESS_ACK);
  assign last    = (io_in_bits_frag == 3'd0);
  // non-final acks are swallowed regardless of the master
  assign drop    = is_ack & ~last;
  assign in_fire = io_in_valid & io_in_ready;

  assign io_in_ready  = drop | io_out_ready;
  assign io_out_valid = io_in_valid & ~drop;

  assign out_denied = sticky_denied | io_in_bits_denied;

  assign io_out_bits_opcode  = io_in_bits_opcode;
  assign io_out_bits_param   = io_in_bits_param;
  assign io_out_bits_source  = io_in_bits_source;
  assign io_out_bits_data    = io_in_bits_data;
  assign io_out_bits_denied  = out_denied;
  assign io_out_bits_corrupt =
    ~is_ack & (io_in_bits_corrupt | out_denied);

  fragment_size_restore u_size (
    .clock    (clock),
    .reset    (reset),
    .in_fire  (in_fire),
    .in_size  (io_in_bits_size),
    .in_frag  (io_in_bits_frag),
    .first    (first),
    .out_size (io_out_bits_size)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_denied <= 1'b0;
    end else if (in_fire) begin
      if (last)
        sticky_denied <= 1'b0;
      else if (first)
        sticky_denied <= io_in_bits_denied;
      else
        sticky_denied <= sticky_denied | io_in_bits_denied;
    end
  end

`ifdef FRAGMENT_COALESCER_CHECK_EN
`ifndef SYNTHESIS
  logic [2:0] prev_frag;
  logic [6:0] head_source;
  logic [2:0] head_opcode;
  logic [2:0] head_size;
  logic [3:0] wide_size;

  assign wide_size = {1'b0, io_in_bits_size}
                   + {1'b0, frag_log2(io_in_bits_frag)};

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_frag   <= 3'd0;
      head_source <= 7'd0;
      head_opcode <= 3'd0;
      head_size   <= 3'd0;
    end else if (in_fire) begin
      prev_frag <= io_in_bits_frag;
      if (first) begin
        head_source <= io_in_bits_source;
        head_opcode <= io_in_bits_opcode;
        head_size   <= io_in_bits_size;
        if (!(io_in_bits_frag inside {3'd0, 3'd1, 3'd3, 3'd7}))
          $error("coalescer: bad first frag src=%0h frag=%0d",
                 io_in_bits_source, io_in_bits_frag);
        if (wide_size > 4'd7)
          $error("coalescer: size overflow src=%0h frag=%0d",
                 io_in_bits_source, io_in_bits_frag);
      end else begin
        if (io_in_bits_frag != prev_frag - 3'd1)
          $error("coalescer: frag skip src=%0h frag=%0d",
                 io_in_bits_source, io_in_bits_frag);
        if (io_in_bits_source != head_source ||
            io_in_bits_opcode != head_opcode ||
            io_in_bits_size   != head_size)
          $error("coalescer: beat mismatch src=%0h frag=%0d",
                 io_in_bits_source, io_in_bits_frag);
      end
    end
  end
`endif
`endif

endmodule

// File: doc/fragment_coalescer.md
# fragment_coalescer

Response-side partner of the A-channel request repeater. It sits on the TileLink D channel between a narrow slave and the fragmenting adapter. The repeater splits one master request into N single-beat fragments; this block turns the N fragment responses back into one master response. AccessAck fragments are merged into a single ack. AccessAckData beats pass through, while size is restored and denied/corrupt are accumulated across the message.

## Interface
Parameters:
- none. Widths are fixed: 64-bit data bus, 7-bit source, fragment size ≤ 8 bytes, so every fragment is exactly one beat.

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- io_in_ready  output  1  D-channel ready toward the slave
- io_in_valid  input  1  fragment beat valid
- io_in_bits_opcode  input  3  0 = AccessAck, 1 = AccessAckData
- io_in_bits_param  input  2  passed through
- io_in_bits_size  input  3  log2 of fragment bytes
- io_in_bits_source  input  7  master source ID
- io_in_bits_frag  input  3  fragments remaining after this beat; 0 = last
- io_in_bits_denied  input  1  fragment denied
- io_in_bits_data  input  64  fragment data
- io_in_bits_corrupt  input  1  fragment data corrupt
- io_out_ready  input  1  master ready
- io_out_valid  output  1  response beat valid
- io_out_bits_opcode / param / source / data  output  3 / 2 / 7 / 64  pass-through of the current input beat
- io_out_bits_size  output  3  restored message size
- io_out_bits_denied  output  1  accumulated denied
- io_out_bits_corrupt  output  1  accumulated corrupt

## Operation
Registers:
- first: 1 means the next beat starts a message.
- saved_size
- sticky_denied
- in_fire = io_in_valid & io_in_ready

Size rule:
- On the first beat, frag+1 ∈ {1,2,4,8} (frag ∈ {0,1,3,7}).
- out size = in_size + log2(frag+1), 3-bit unsigned.
- Legal combinations never exceed 7.
- On later beats, out size = saved_size.

AccessAck (opcode 0):
- frag≠0: beat is dropped. io_in_ready=1, io_out_valid=0, io_out_ready is ignored.
- frag=0: io_out_valid=io_in_valid and io_in_ready=io_out_ready.
- Emitted denied = sticky_denied | in_denied.
- Emitted corrupt = 0.

AccessAckData (opcode 1):
- Every beat is forwarded: io_out_valid=io_in_valid, io_in_ready=io_out_ready.
- out_denied = sticky_denied | in_denied.
- out_corrupt = in_corrupt | out_denied.

On in_fire:
- If first: latch saved_size from the computed value.
- sticky_denied <= (frag==0) ? 0 : (first ? in_denied : sticky_denied | in_denied).
- first <= (frag==0).

Single-fragment message (frag=0 on the first beat): the block behaves as a wire, with size unchanged.

Messages from different sources are never interleaved on the input. The fragmenter guarantees this, and the block relies on it.

## Timing
- Zero-latency combinational forward path. No data storage.
- Register updates occur only on in_fire, at the next rising edge.
- Reset values: first=1, sticky_denied=0, saved_size=0.
- io_out_valid=0 while io_in_valid=0, including during reset. io_in_ready follows io_out_ready.
- Stall rule: while the slave holds a beat and io_out_ready=0, the beat is not consumed and no state changes.
- Reset mid-message: the partial message is abandoned and the next input beat is treated as first.
- Last beat with io_out_ready=0: first stays 0 until the beat fires.

## Configuration
- FRAGMENT_COALESCER_CHECK_EN defined: simulation-only assertions under `ifndef SYNTHESIS`. They are checked on every in_fire and fire `$error` with source and frag values:
  - first-beat frag ∈ {0,1,3,7};
  - on non-first beats, frag equals the previous frag−1, and source, opcode and size equal those of the first beat;
  - computed out size ≤ 7 with no carry.
  - Previous-beat shadow registers exist only in this build.
- Undefined: no checks and no shadow registers. Functional behaviour is identical in both builds.

## Structure
- Shared package tl_d_pkg:
  - D opcode constants ACCESS_ACK=3'd0 and ACCESS_ACK_DATA=3'd1;
  - FRAG_W=3 and a frag_log2 function mapping {0,1,3,7} to {0,1,2,3}.
- One natural sub-module: fragment_size_restore. It holds the combinational size adder plus the saved_size register and first flag. The top level holds the opcode-dependent handshake muxing and denied/corrupt accumulation.

## Test plan
- Write of 4 fragments (opcode 0, size 3, frag 3,2,1,0; source 0x15; io_out_ready=1):
  - exactly one output beat, on the frag=0 cycle;
  - size=5, source=0x15, denied=0.
- Same write with denied=1 on the frag=2 beat only:
  - single output ack with denied=1;
  - next message's ack has denied=0.
- Read of 2 fragments (opcode 1, size 3, data 0xA, 0xB):
  - two output beats, data 0xA then 0xB, both size=4;
  - corrupt=1 on the second beat only when its in_corrupt=1.
- Backpressure: io_out_ready=0 for 3 cycles on the frag=0 write beat:
  - io_in_ready=0 and io_out_valid=1 held;
  - the beat completes on the first ready cycle, then first=1.
- Reset asserted after frag=3 and frag=2 of a write, then a new frag=0 write (size 2, denied 0) arrives:
  - output ack with size=2, denied=0.
- With FRAGMENT_COALESCER_CHECK_EN defined, drive frag sequence 3, 1:
  - the assertion fires;
  - without the macro, simulation is silent.
